// File: rtl/case_5_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : case_5_mul_pkg
//  Description : Shared constants and helpers for the case_5_mul pipelined
//                multiplier: full product width, legal pipeline depth and
//                clamp bounds used by the saturation unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package case_5_mul_pkg;

    // Legal pipeline depth, in enabled clock edges
    localparam int NUM_STAGE_MIN = 1;
    localparam int NUM_STAGE_MAX = 4;

    // Width of the clamp bound container; result widths up to this are supported
    localparam int BOUND_W = 64;

    // Each operand gains one extension bit, so the exact signed product
    // needs both widths plus two bits
    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1 + 2;
    endfunction

    // Largest (want_max=1) or smallest (want_max=0) representable value of a
    // 'width'-bit result, returned in two's complement in BOUND_W bits
    function automatic logic [BOUND_W-1:0] clamp_bound(input int width,
                                                       input logic is_signed,
                                                       input logic want_max);
        logic [BOUND_W-1:0] mag;
        logic [BOUND_W-1:0] bound;
        if (is_signed) begin
            mag   = (BOUND_W'(1) << (width - 1)) - BOUND_W'(1);
            bound = want_max ? mag : ~mag;
        end else begin
            mag   = (BOUND_W'(1) << width) - BOUND_W'(1);
            bound = want_max ? mag : '0;
        end
        return bound;
    endfunction

endpackage
`default_nettype wire

// File: rtl/case_5_mul_sat.sv
`default_nettype none
// ============================================================================
//  Module      : case_5_mul_sat
//  Description : Combinational truncate/saturate unit. Reduces the full-width
//                signed product to the result width and flags overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module case_5_mul_sat
    import case_5_mul_pkg::*;
#(
    parameter int P          = 15,
    parameter int dout_WIDTH = 11,
    parameter int SAT        = 0
) (
    input  logic signed [P-1:0]          prod,
    input  logic                         res_signed,
    output logic        [dout_WIDTH-1:0] dout,
    output logic                         ovf
);

    generate
        if (dout_WIDTH >= P - 1) begin : g_exact
            // The product always fits: sign- or zero-extend it unchanged
            assign dout = res_signed ? dout_WIDTH'(prod) : dout_WIDTH'($unsigned(prod));
            assign ovf  = 1'b0;
        end else begin : g_clip
            logic [P-dout_WIDTH:0]   w_hi_s;
            logic [P-dout_WIDTH-1:0] w_hi_u;
            logic                    w_ovf_s;
            logic                    w_ovf_u;
            logic                    w_want_max;
            logic                    w_use_bound;
            logic [dout_WIDTH-1:0]   w_bound;

            // Signed fit: every bit from the result sign bit upward must agree
            assign w_hi_s  = prod[P-1:dout_WIDTH-1];
            assign w_ovf_s = ~((&w_hi_s) | ~(|w_hi_s));

            // Unsigned fit: nothing above the result width may be set
            assign w_hi_u  = prod[P-1:dout_WIDTH];
            assign w_ovf_u = |w_hi_u;

            assign ovf = res_signed ? w_ovf_s : w_ovf_u;

            // Unsigned products are never negative, so they only clamp high
            assign w_want_max  = ~(res_signed & prod[P-1]);
            assign w_bound     = dout_WIDTH'(clamp_bound(dout_WIDTH, res_signed, w_want_max));
            assign w_use_bound = (SAT != 0) && ovf;

            assign dout = w_use_bound ? w_bound : prod[dout_WIDTH-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/case_5_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : case_5_mul_pipe
//  Description : Pipelined multiplier with per-operand run-time signedness,
//                valid tracking, clock-enable stall and truncating or
//                saturating result. Operands are registered in stage 0, the
//                multiply follows, optional delay stages come next and the
//                truncate/saturate step feeds the output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module case_5_mul_pipe
    import case_5_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 8,
    parameter int din1_WIDTH = 5,
    parameter int dout_WIDTH = 11,
    parameter int SAT        = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  din_vld,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  din0_signed,
    input  logic                  din1_signed,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  dout_vld,
    output logic                  dout_ovf
);

    localparam int P   = prod_width(din0_WIDTH, din1_WIDTH);
    // Number of pure product delay registers between the multiply and the output
    localparam int DLY = (NUM_STAGE >= 2) ? NUM_STAGE - 2 : 0;

    generate
        if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_num_stage
            $error("case_5_mul_pipe ID=%0d: NUM_STAGE=%0d is outside 1..4", ID, NUM_STAGE);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Operand source: stage 0 registers, or the raw inputs for a 1-deep pipe
    // ------------------------------------------------------------------------
    logic [din0_WIDTH-1:0] w_op0;
    logic [din1_WIDTH-1:0] w_op1;
    logic                  w_op0_signed;
    logic                  w_op1_signed;
    logic                  w_op_vld;

    generate
        if (NUM_STAGE >= 2) begin : g_stage0
            logic [din0_WIDTH-1:0] r_op0;
            logic [din1_WIDTH-1:0] r_op1;
            logic                  r_op0_signed;
            logic                  r_op1_signed;
            logic                  r_vld;

            // Capture operands on every enabled edge; din_vld only tags them
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_op0        <= '0;
                    r_op1        <= '0;
                    r_op0_signed <= 1'b0;
                    r_op1_signed <= 1'b0;
                    r_vld        <= 1'b0;
                end else if (ce) begin
                    r_op0        <= din0;
                    r_op1        <= din1;
                    r_op0_signed <= din0_signed;
                    r_op1_signed <= din1_signed;
                    r_vld        <= din_vld;
                end
            end

            assign w_op0        = r_op0;
            assign w_op1        = r_op1;
            assign w_op0_signed = r_op0_signed;
            assign w_op1_signed = r_op1_signed;
            assign w_op_vld     = r_vld;
        end else begin : g_stage0_bypass
            assign w_op0        = din0;
            assign w_op1        = din1;
            assign w_op0_signed = din0_signed;
            assign w_op1_signed = din1_signed;
            assign w_op_vld     = din_vld;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Full-width multiply on one-bit-extended operands
    // ------------------------------------------------------------------------
    logic signed [din0_WIDTH:0] w_ext0;
    logic signed [din1_WIDTH:0] w_ext1;
    logic signed [P-1:0]        w_mul;
    logic                       w_mul_signed;

    assign w_ext0       = {w_op0_signed & w_op0[din0_WIDTH-1], w_op0};
    assign w_ext1       = {w_op1_signed & w_op1[din1_WIDTH-1], w_op1};
    assign w_mul        = P'(w_ext0) * P'(w_ext1);
    assign w_mul_signed = w_op0_signed | w_op1_signed;

    // ------------------------------------------------------------------------
    // Product delay chain; index 0 is the multiplier output itself
    // ------------------------------------------------------------------------
    logic signed [P-1:0] w_pchain [0:DLY];
    logic                w_vchain [0:DLY];
    logic                w_schain [0:DLY];

    assign w_pchain[0] = w_mul;
    assign w_vchain[0] = w_op_vld;
    assign w_schain[0] = w_mul_signed;

    generate
        for (genvar j = 1; j <= DLY; j++) begin : g_delay
            logic signed [P-1:0] r_prod;
            logic                r_vld;
            logic                r_res_signed;

            // Pure delay stage, frozen while ce is low
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_prod       <= '0;
                    r_vld        <= 1'b0;
                    r_res_signed <= 1'b0;
                end else if (ce) begin
                    r_prod       <= w_pchain[j-1];
                    r_vld        <= w_vchain[j-1];
                    r_res_signed <= w_schain[j-1];
                end
            end

            assign w_pchain[j] = r_prod;
            assign w_vchain[j] = r_vld;
            assign w_schain[j] = r_res_signed;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Final stage: truncate/saturate feeding the output register
    // ------------------------------------------------------------------------
    logic [dout_WIDTH-1:0] w_sat_dout;
    logic                  w_sat_ovf;

    case_5_mul_sat #(
        .P          (P),
        .dout_WIDTH (dout_WIDTH),
        .SAT        (SAT)
    ) u_sat (
        .prod       (w_pchain[DLY]),
        .res_signed (w_schain[DLY]),
        .dout       (w_sat_dout),
        .ovf        (w_sat_ovf)
    );

    // Output register: result and overflow only move when a valid result lands
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_ovf <= 1'b0;
        end else if (ce) begin
            dout_vld <= w_vchain[DLY];
            if (w_vchain[DLY]) begin
                dout     <= w_sat_dout;
                dout_ovf <= w_sat_ovf;
            end
        end
    end

endmodule
`default_nettype wire
